// File: rtl/scan_pkg.sv
// Shared types and constants for the scan sequencer that drives a 74x138-style
// decoder select/enable group.
package scan_pkg;

   localparam logic [2:0] G_EN  = 3'b100;
   localparam logic [2:0] G_DIS = 3'b011;

   typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;

   typedef logic [2:0] sel_t;
   typedef logic [7:0] mask_t;

   // Lowest set bit of m; 0 when m is empty.
   function automatic sel_t lowest_bit(input mask_t m);
      sel_t r;
      r = '0;
      for (int unsigned i = 8; i > 0; i--) begin
         if (m[i-1]) r = sel_t'(i - 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/next_slot.sv
// Combinational slot stepper: first set mask bit above cur, searching upward
// modulo 8. wrap flags a result at or below cur (including an empty mask).
module next_slot
   import scan_pkg::*;
(
   input  mask_t mask,
   input  sel_t  cur,
   output sel_t  nxt,
   output logic  wrap
);

   logic [15:0] dbl;
   logic [3:0]  sh;
   mask_t       rot;
   sel_t        off;

   // Rotate so bit 0 of rot is slot cur+1, then priority-encode from bit 0.
   always_comb begin
      dbl = {mask, mask};
      sh  = {1'b0, cur} + 4'd1;
      rot = mask_t'(dbl >> sh);
      off = 3'd7;
      for (int unsigned i = 8; i > 0; i--) begin
         if (rot[i-1]) off = sel_t'(i - 1);
      end
      nxt  = cur + off + 3'd1;
      wrap = (nxt <= cur);
   end

endmodule

// File: rtl/scan_sequencer.sv
// Steps a 3-bit decoder select through the slots enabled in mask, with a
// programmable dwell per slot and a break-before-make blanking gap.
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int unsigned DWELL_CYC = 4,
   parameter int unsigned BLANK_CYC = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       cont,
   input  logic [7:0] mask,
   output logic [2:0] s,
   output logic [2:0] g,
   output logic       busy,
   output logic       frame_done
);

   localparam int unsigned MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int unsigned CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] DW_LAST = CW'(DWELL_CYC - 1);
   localparam logic [CW-1:0] BL_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam state_t ENTRY = (BLANK_CYC == 0) ? DWELL : BLANK;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   mask_t         mask_q, mask_q_nxt;
   logic          cont_q, cont_q_nxt;
   sel_t          s_nxt;
   logic [2:0]    g_nxt;
   logic          busy_nxt, fd_nxt;

   sel_t          step_sel;
   logic          step_wrap;
   logic          dwell_end;

   next_slot u_next_slot (
      .mask (mask_q),
      .cur  (s),
      .nxt  (step_sel),
      .wrap (step_wrap)
   );

   assign dwell_end = (state == DWELL) && (cnt == DW_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         mask_q     <= '0;
         cont_q     <= 1'b0;
         s          <= '0;
         g          <= G_DIS;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         mask_q     <= mask_q_nxt;
         cont_q     <= cont_q_nxt;
         s          <= s_nxt;
         g          <= g_nxt;
         busy       <= busy_nxt;
         frame_done <= fd_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start && !stop && (mask != '0)) state_nxt = ENTRY;
         end
         BLANK: begin
            if (stop)                 state_nxt = IDLE;
            else if (cnt == BL_LAST)  state_nxt = DWELL;
         end
         DWELL: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (dwell_end) begin
               if (step_wrap && ((mask == '0) || !cont_q)) state_nxt = IDLE;
               else                                       state_nxt = ENTRY;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered: this computes the values loaded on the next edge.
   always_comb begin
      s_nxt      = s;
      mask_q_nxt = mask_q;
      cont_q_nxt = cont_q;
      fd_nxt     = 1'b0;
      g_nxt      = (state_nxt == DWELL) ? G_EN : G_DIS;
      busy_nxt   = (state_nxt != IDLE);

      if ((state_nxt == IDLE) || (state_nxt != state) || dwell_end) cnt_nxt = '0;
      else                                                         cnt_nxt = cnt + 1'b1;

      if ((state == IDLE) && (state_nxt != IDLE)) begin
         s_nxt      = lowest_bit(mask);
         mask_q_nxt = mask;
         cont_q_nxt = cont;
      end else if (dwell_end && !stop) begin
         if (step_wrap) begin
            // A new frame starts from the freshly reloaded mask, not mask_q.
            fd_nxt     = 1'b1;
            mask_q_nxt = mask;
            if (state_nxt != IDLE) s_nxt = lowest_bit(mask);
         end else begin
            s_nxt = step_sel;
         end
      end
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed self-checking bench for scan_sequencer: default-parameter instance
// plus a no-blanking instance, expected values hand-derived from slot timing.
module tb_scan_sequencer;

   localparam logic [2:0] EN  = 3'b100;
   localparam logic [2:0] DIS = 3'b011;

   logic       clk, rst, stop, cont;
   logic       start_a, start_b;
   logic [7:0] mask;
   logic [2:0] s_a, g_a, s_b, g_b;
   logic       busy_a, fd_a, busy_b, fd_b;

   int errors = 0;
   int checks = 0;

   scan_sequencer u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start_a),
      .stop       (stop),
      .cont       (cont),
      .mask       (mask),
      .s          (s_a),
      .g          (g_a),
      .busy       (busy_a),
      .frame_done (fd_a)
   );

   scan_sequencer #(.DWELL_CYC(4), .BLANK_CYC(0)) u_nb (
      .clk        (clk),
      .rst        (rst),
      .start      (start_b),
      .stop       (stop),
      .cont       (cont),
      .mask       (mask),
      .s          (s_b),
      .g          (g_b),
      .busy       (busy_b),
      .frame_done (fd_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_a(input string tag, input logic [2:0] es, input logic [2:0] eg,
                           input logic eb, input logic ef);
      chk({tag, ".s"},    {5'd0, s_a},    {5'd0, es});
      chk({tag, ".g"},    {5'd0, g_a},    {5'd0, eg});
      chk({tag, ".busy"}, {7'd0, busy_a}, {7'd0, eb});
      chk({tag, ".fd"},   {7'd0, fd_a},   {7'd0, ef});
   endtask

   initial begin
      logic [2:0] seq3 [3];
      logic [2:0] seqr [6];
      logic [2:0] prev_s;
      logic [2:0] eg;

      seq3 = '{3'd2, 3'd5, 3'd7};
      seqr = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd4, 3'd5};

      rst = 1'b1; stop = 1'b0; cont = 1'b0; start_a = 1'b0; start_b = 1'b0; mask = '0;
      step();
      step();
      expect_a("reset", 3'd0, DIS, 1'b0, 1'b0);
      chk("reset_b.g", {5'd0, g_b}, {5'd0, DIS});
      chk("reset_b.busy", {7'd0, busy_b}, 8'd0);
      rst = 1'b0;

      // Full mask, single shot
      mask = 8'hFF; cont = 1'b0; start_a = 1'b1;
      step();
      expect_a("full.t0", 3'd0, DIS, 1'b1, 1'b0);
      start_a = 1'b0;
      for (int t = 1; t <= 40; t++) begin
         step();
         if (t < 40) begin
            eg = (t % 5 == 0) ? DIS : EN;
            expect_a($sformatf("full.t%0d", t), 3'(t / 5), eg, 1'b1, 1'b0);
         end else begin
            expect_a("full.end", 3'd7, DIS, 1'b0, 1'b1);
         end
      end
      step();
      expect_a("full.idle", 3'd7, DIS, 1'b0, 1'b0);

      // Sparse mask, continuous
      mask = 8'b1010_0100; cont = 1'b1; start_a = 1'b1;
      step();
      expect_a("sparse.t0", 3'd2, DIS, 1'b1, 1'b0);
      start_a = 1'b0;
      prev_s = s_a;
      for (int t = 1; t <= 45; t++) begin
         step();
         eg = (t % 5 == 0) ? DIS : EN;
         expect_a($sformatf("sparse.t%0d", t), seq3[(t / 5) % 3], eg, 1'b1, (t % 15 == 0));
         if (s_a != prev_s) chk($sformatf("sparse.bbm.t%0d", t), {5'd0, g_a}, {5'd0, DIS});
         prev_s = s_a;
      end
      stop = 1'b1;
      step();
      chk("sparse.stop.g", {5'd0, g_a}, {5'd0, DIS});
      chk("sparse.stop.busy", {7'd0, busy_a}, 8'd0);
      chk("sparse.stop.fd", {7'd0, fd_a}, 8'd0);
      stop = 1'b0;

      // Single bit, no blanking
      mask = 8'h08; cont = 1'b1; start_b = 1'b1;
      step();
      chk("nb.t0.s", {5'd0, s_b}, 8'd3);
      chk("nb.t0.g", {5'd0, g_b}, {5'd0, EN});
      chk("nb.t0.busy", {7'd0, busy_b}, 8'd1);
      start_b = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         step();
         chk($sformatf("nb.t%0d.s", t), {5'd0, s_b}, 8'd3);
         chk($sformatf("nb.t%0d.g", t), {5'd0, g_b}, {5'd0, EN});
         chk($sformatf("nb.t%0d.fd", t), {7'd0, fd_b}, {7'd0, (t % 4 == 0)});
      end
      stop = 1'b1;
      step();
      chk("nb.stop.g", {5'd0, g_b}, {5'd0, DIS});
      chk("nb.stop.busy", {7'd0, busy_b}, 8'd0);
      stop = 1'b0;

      // start together with stop is ignored
      mask = 8'hFF; start_a = 1'b1; stop = 1'b1;
      step();
      chk("coll.busy", {7'd0, busy_a}, 8'd0);
      chk("coll.g", {5'd0, g_a}, {5'd0, DIS});
      start_a = 1'b0; stop = 1'b0;
      step();
      chk("coll.busy2", {7'd0, busy_a}, 8'd0);

      // start with an empty mask is ignored
      mask = 8'h00; start_a = 1'b1;
      step();
      chk("zero.busy", {7'd0, busy_a}, 8'd0);
      chk("zero.g", {5'd0, g_a}, {5'd0, DIS});
      start_a = 1'b0;

      // stop during the dwell of slot 4
      mask = 8'h10; cont = 1'b0; start_a = 1'b1;
      step();
      expect_a("stop4.t0", 3'd4, DIS, 1'b1, 1'b0);
      start_a = 1'b0;
      step();
      chk("stop4.t1.g", {5'd0, g_a}, {5'd0, EN});
      step();
      chk("stop4.t2.g", {5'd0, g_a}, {5'd0, EN});
      stop = 1'b1;
      step();
      chk("stop4.g", {5'd0, g_a}, {5'd0, DIS});
      chk("stop4.busy", {7'd0, busy_a}, 8'd0);
      chk("stop4.fd", {7'd0, fd_a}, 8'd0);
      stop = 1'b0;
      step();
      chk("stop4.fd2", {7'd0, fd_a}, 8'd0);
      chk("stop4.busy2", {7'd0, busy_a}, 8'd0);

      // Mask reload at frame wrap, then empty mask ends the scan
      mask = 8'h03; cont = 1'b1; start_a = 1'b1;
      step();
      expect_a("reload.t0", 3'd0, DIS, 1'b1, 1'b0);
      start_a = 1'b0;
      mask = 8'h30;
      for (int t = 1; t <= 30; t++) begin
         step();
         if (t < 30) begin
            eg = (t % 5 == 0) ? DIS : EN;
            expect_a($sformatf("reload.t%0d", t), seqr[t / 5], eg, 1'b1, (t == 10 || t == 20));
         end else begin
            expect_a("reload.end", 3'd5, DIS, 1'b0, 1'b1);
         end
         if (t == 20) mask = 8'h00;
      end
      step();
      expect_a("reload.idle", 3'd5, DIS, 1'b0, 1'b0);

      // Reset in the middle of a dwell
      mask = 8'hFF; cont = 1'b1; start_a = 1'b1;
      step();
      start_a = 1'b0;
      step();
      step();
      chk("rstmid.pre.g", {5'd0, g_a}, {5'd0, EN});
      rst = 1'b1;
      step();
      expect_a("rstmid.e1", 3'd0, DIS, 1'b0, 1'b0);
      step();
      expect_a("rstmid.e2", 3'd0, DIS, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      expect_a("rstmid.after", 3'd0, DIS, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
